// File: rtl/jam_pkg.sv
// Shared widths and FSM state encoding for the JAM cost-lookup responder.
package jam_pkg;

  localparam int COST_W      = 7;
  localparam int MIN_COST_W  = 9;
  localparam int MATCH_W     = 4;
  localparam int IDX_W       = 3;
  localparam int TABLE_DEPTH = 64;
  localparam int CNT_W       = 24;
  localparam int ADDR_W      = 2 * IDX_W;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_READY,
    ST_HOLD,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/jam_cost_table.sv
// 64x7 worker/job cost register file: one synchronous write port,
// one combinational read port, asynchronous clear.
module jam_cost_table
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [COST_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [COST_W-1:0] o_rdata
);

  logic [COST_W-1:0] r_mem [TABLE_DEPTH];

  // NOTE: this storage is deliberately reset; a reset must make every lookup return 0.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < TABLE_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/jam_cost_server.sv
// Cost-table server for the JAM: loads the table, sequences JAM reset and
// run, and captures MinCost/MatchCount on Valid or on timeout.
module jam_cost_server
  import jam_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10_000_000,
  parameter int RST_HOLD       = 3
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [COST_W-1:0]     load_data,
  input  logic                  start,
  input  logic                  reload,
  output logic                  jam_rst,
  input  logic [IDX_W-1:0]      W,
  input  logic [IDX_W-1:0]      J,
  output logic [COST_W-1:0]     Cost,
  input  logic                  Valid,
  input  logic [MIN_COST_W-1:0] MinCost,
  input  logic [MATCH_W-1:0]    MatchCount,
  output logic                  done,
  output logic                  timeout,
  output logic [MIN_COST_W-1:0] res_min_cost,
  output logic [MATCH_W-1:0]    res_match_count,
  output logic [CNT_W-1:0]      run_cycles
);

  state_e                r_state;
  logic [ADDR_W-1:0]     r_ptr;
  logic [3:0]            r_hold_cnt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_load_ready;
  logic                  r_jam_rst;
  logic                  r_done;
  logic                  r_timeout;
  logic [MIN_COST_W-1:0] r_res_min_cost;
  logic [MATCH_W-1:0]    r_res_match_count;
  logic [CNT_W-1:0]      r_run_cycles;

  logic                  w_accept;
  logic [CNT_W-1:0]      w_cnt_now;
  logic                  w_timeout_hit;

  assign w_accept      = load_valid && (r_state == ST_LOAD);
  // r_cnt holds the previous RUN cycle's count, so the live count is one ahead.
  assign w_cnt_now     = r_cnt + 1'b1;
  assign w_timeout_hit = (w_cnt_now == CNT_W'(TIMEOUT_CYCLES));

  jam_cost_table u_table (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .i_we    (w_accept),
    .i_waddr (r_ptr),
    .i_wdata (load_data),
    .i_raddr ({W, J}),
    .o_rdata (Cost)
  );

  // jam_rst and load_ready are registered so the JAM reset line never glitches on state decode.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state           <= ST_LOAD;
      r_ptr             <= '0;
      r_hold_cnt        <= '0;
      r_cnt             <= '0;
      r_load_ready      <= 1'b1;
      r_jam_rst         <= 1'b1;
      r_done            <= 1'b0;
      r_timeout         <= 1'b0;
      r_res_min_cost    <= '0;
      r_res_match_count <= '0;
      r_run_cycles      <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == ADDR_W'(TABLE_DEPTH - 1)) begin
              r_state      <= ST_READY;
              r_load_ready <= 1'b0;
            end
          end
        end
        ST_READY, ST_DONE: begin
          if (reload) begin
            r_state      <= ST_LOAD;
            r_ptr        <= '0;
            r_load_ready <= 1'b1;
          end else if (start) begin
            r_state      <= ST_HOLD;
            r_hold_cnt   <= '0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_run_cycles <= '0;
          end
        end
        ST_HOLD: begin
          r_cnt <= '0;
          if (r_hold_cnt == 4'(RST_HOLD - 1)) begin
            r_state   <= ST_RUN;
            r_jam_rst <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_cnt <= w_cnt_now;
          if (Valid) begin
            r_state           <= ST_DONE;
            r_jam_rst         <= 1'b1;
            r_done            <= 1'b1;
            r_res_min_cost    <= MinCost;
            r_res_match_count <= MatchCount;
            r_run_cycles      <= w_cnt_now;
          end else if (w_timeout_hit) begin
            r_state           <= ST_DONE;
            r_jam_rst         <= 1'b1;
            r_done            <= 1'b1;
            r_timeout         <= 1'b1;
            r_res_min_cost    <= '0;
            r_res_match_count <= '0;
            r_run_cycles      <= w_cnt_now;
          end
        end
        default: begin
          r_state      <= ST_LOAD;
          r_ptr        <= '0;
          r_load_ready <= 1'b1;
          r_jam_rst    <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready      = r_load_ready;
  assign jam_rst         = r_jam_rst;
  assign done            = r_done;
  assign timeout         = r_timeout;
  assign res_min_cost    = r_res_min_cost;
  assign res_match_count = r_res_match_count;
  assign run_cycles      = r_run_cycles;

endmodule

// File: tb/tb_jam_cost_server.sv
// Directed bench: dut_a uses the default timeout, dut_b a 50-cycle timeout;
// both share every input so one stimulus stream exercises both limits.
module tb_jam_cost_server;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [6:0] load_data;
  logic       start;
  logic       reload;
  logic [2:0] w;
  logic [2:0] j;
  logic       valid;
  logic [8:0] min_cost;
  logic [3:0] match_count;

  logic        a_load_ready, a_jam_rst, a_done, a_timeout;
  logic [6:0]  a_cost;
  logic [8:0]  a_res_min;
  logic [3:0]  a_res_match;
  logic [23:0] a_run_cycles;
  logic        b_load_ready, b_jam_rst, b_done, b_timeout;
  logic [6:0]  b_cost;
  logic [8:0]  b_res_min;
  logic [3:0]  b_res_match;
  logic [23:0] b_run_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jam_cost_server dut_a (
    .CLK (clk), .RST_n (rst_n),
    .load_valid (load_valid), .load_ready (a_load_ready), .load_data (load_data),
    .start (start), .reload (reload), .jam_rst (a_jam_rst),
    .W (w), .J (j), .Cost (a_cost),
    .Valid (valid), .MinCost (min_cost), .MatchCount (match_count),
    .done (a_done), .timeout (a_timeout), .res_min_cost (a_res_min),
    .res_match_count (a_res_match), .run_cycles (a_run_cycles)
  );

  jam_cost_server #(.TIMEOUT_CYCLES(50)) dut_b (
    .CLK (clk), .RST_n (rst_n),
    .load_valid (load_valid), .load_ready (b_load_ready), .load_data (load_data),
    .start (start), .reload (reload), .jam_rst (b_jam_rst),
    .W (w), .J (j), .Cost (b_cost),
    .Valid (valid), .MinCost (min_cost), .MatchCount (match_count),
    .done (b_done), .timeout (b_timeout), .res_min_cost (b_res_min),
    .res_match_count (b_res_match), .run_cycles (b_run_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input int wi, input int ji);
    w = 3'(wi);
    j = 3'(ji);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Walks the HOLD phase, checking jam_rst each cycle, and lands in RUN cycle 1.
  task automatic hold_phase(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_hold_jam_rst"}, 32'(a_jam_rst), 1);
      tick();
    end
    check({tag, "_run_jam_rst"}, 32'(a_jam_rst), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; start = 1'b0; reload = 1'b0;
    w = '0; j = '0; valid = 1'b0; min_cost = '0; match_count = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_load_ready", 32'(a_load_ready), 1);
    check("rst_jam_rst",    32'(a_jam_rst), 1);
    check("rst_done",       32'(a_done), 0);
    check("rst_timeout",    32'(a_timeout), 0);
    check("rst_run_cycles", 32'(a_run_cycles), 0);
    lookup(5, 3);
    check("rst_cost",       32'(a_cost), 0);

    // Contiguous load of W*8+J
    for (int idx = 0; idx < 64; idx++) begin
      load_valid = 1'b1;
      load_data  = 7'(idx);
      if (idx == 9) begin
        lookup(1, 1);
        check("write_not_same_cycle", 32'(a_cost), 0);
      end
      if (idx == 63) check("ready_before_last", 32'(a_load_ready), 1);
      tick();
      if (idx == 9) begin
        lookup(1, 1);
        check("write_next_cycle", 32'(a_cost), 9);
      end
    end
    load_valid = 1'b0;
    check("ready_after_64", 32'(a_load_ready), 0);
    lookup(5, 3);
    check("cost_5_3", 32'(a_cost), 43);
    lookup(7, 7);
    check("cost_7_7", 32'(a_cost), 63);
    check("cost_7_7_b", 32'(b_cost), 63);

    // Reset clears the table, then a stalled reload of the same pattern
    rst_n = 1'b0;
    #1;
    check("rst2_cost", 32'(a_cost), 0);
    check("rst2_load_ready", 32'(a_load_ready), 1);
    #1 rst_n = 1'b1;
    tick();
    for (int idx = 0; idx < 64; idx++) begin
      load_valid = 1'b1;
      load_data  = 7'(idx);
      tick();
      load_valid = 1'b0;
      load_data  = 7'd127;
      tick();
      if (idx == 62) check("stall_ready_at_63", 32'(a_load_ready), 1);
    end
    check("stall_ready_after_64", 32'(a_load_ready), 0);
    for (int wi = 0; wi < 8; wi++)
      for (int ji = 0; ji < 8; ji++) begin
        lookup(wi, ji);
        check("stall_cost", 32'(a_cost), 32'(wi * 8 + ji));
      end

    // Nominal run: Valid in RUN cycle 100 (dut_b times out at 50)
    min_cost = 9'd245;
    match_count = 4'd2;
    pulse_start();
    hold_phase("nom");
    check("nom_done_low", 32'(a_done), 0);
    repeat (99) tick();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("nom_done",      32'(a_done), 1);
    check("nom_min_cost",  32'(a_res_min), 245);
    check("nom_match",     32'(a_res_match), 2);
    check("nom_cycles",    32'(a_run_cycles), 100);
    check("nom_timeout",   32'(a_timeout), 0);
    check("nom_jam_rst",   32'(a_jam_rst), 1);
    check("nomb_done",     32'(b_done), 1);
    check("nomb_timeout",  32'(b_timeout), 1);
    check("nomb_cycles",   32'(b_run_cycles), 50);
    check("nomb_min_cost", 32'(b_res_min), 0);

    // Timeout on dut_b with no Valid; dut_a finishes at cycle 60
    min_cost = 9'd300;
    match_count = 4'd7;
    pulse_start();
    check("to_done_cleared",   32'(a_done), 0);
    check("to_cycles_cleared", 32'(a_run_cycles), 0);
    hold_phase("to");
    repeat (50) tick();
    check("tob_done",     32'(b_done), 1);
    check("tob_timeout",  32'(b_timeout), 1);
    check("tob_min_cost", 32'(b_res_min), 0);
    check("tob_match",    32'(b_res_match), 0);
    check("tob_cycles",   32'(b_run_cycles), 50);
    check("tob_jam_rst",  32'(b_jam_rst), 1);
    check("toa_running",  32'(a_jam_rst), 0);
    check("toa_done_low", 32'(a_done), 0);
    repeat (9) tick();
    min_cost = 9'd17;
    match_count = 4'd5;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("toa_cycles",   32'(a_run_cycles), 60);
    check("toa_min_cost", 32'(a_res_min), 17);
    check("toa_match",    32'(a_res_match), 5);
    check("tob_ignores_valid", 32'(b_res_min), 0);

    // Valid in the same cycle as the timeout: Valid wins
    min_cost = 9'd100;
    match_count = 4'd9;
    pulse_start();
    hold_phase("tie");
    repeat (49) tick();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("tieb_done",     32'(b_done), 1);
    check("tieb_timeout",  32'(b_timeout), 0);
    check("tieb_cycles",   32'(b_run_cycles), 50);
    check("tieb_min_cost", 32'(b_res_min), 100);
    check("tieb_match",    32'(b_res_match), 9);
    check("tiea_cycles",   32'(a_run_cycles), 50);

    // start + reload together in DONE: reload wins
    start = 1'b1;
    reload = 1'b1;
    tick();
    start = 1'b0;
    reload = 1'b0;
    check("col_load_ready", 32'(a_load_ready), 1);
    check("col_done_held",  32'(a_done), 1);
    check("col_jam_rst",    32'(a_jam_rst), 1);
    lookup(5, 3);
    check("col_old_table",  32'(a_cost), 43);
    pulse_start();
    check("col_start_ignored_ready", 32'(a_load_ready), 1);
    check("col_start_ignored_done",  32'(a_done), 1);
    load_valid = 1'b1;
    load_data  = 7'd99;
    tick();
    load_valid = 1'b0;
    lookup(0, 0);
    check("col_overwrite", 32'(a_cost), 99);
    lookup(0, 1);
    check("col_kept",      32'(a_cost), 1);
    for (int idx = 1; idx < 64; idx++) begin
      load_valid = 1'b1;
      load_data  = 7'(idx);
      tick();
    end
    load_valid = 1'b0;
    check("col_reloaded", 32'(a_load_ready), 0);
    pulse_start();
    check("col_done_cleared", 32'(a_done), 0);

    // Asynchronous reset in RUN cycle 20
    hold_phase("mid");
    repeat (19) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_jam_rst",    32'(a_jam_rst), 1);
    check("mid_done",       32'(a_done), 0);
    check("mid_res_min",    32'(a_res_min), 0);
    check("mid_load_ready", 32'(a_load_ready), 1);
    for (int wi = 0; wi < 8; wi++)
      for (int ji = 0; ji < 8; ji++) begin
        lookup(wi, ji);
        check("mid_cost", 32'(a_cost), 0);
      end
    rst_n = 1'b1;
    tick();
    check("post_load_ready", 32'(a_load_ready), 1);
    check("post_jam_rst",    32'(a_jam_rst), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jam_cost_server.md
# jam_cost_server

Responder side of the JAM cost-lookup interface: holds the 8×8 worker/job cost table, answers the JAM's `W`/`J` address with `Cost` in the same cycle, and sequences the JAM's reset, run and result capture. It sits beside the JAM in the integrated design. It is loaded over a ready/valid byte stream, releases the JAM from reset on `start`, and latches `MinCost`/`MatchCount` on `Valid` or on timeout.

## Interface
- `TIMEOUT_CYCLES`, default 10_000_000: maximum RUN cycles before the run is aborted; must fit in 24 bits.
- `RST_HOLD`, default 3: number of cycles `jam_rst` is held high in HOLD; range 1..15.
- `CLK` in 1: the single clock; all logic on its rising edge.
- `RST_n` in 1: asynchronous, active-low reset.
- `load_valid` in 1, `load_ready` out 1, `load_data` in 7: cost stream, row-major, entry index = W*8+J.
- `start` in 1: single-cycle pulse; begins a run.
- `reload` in 1: single-cycle pulse; returns the block to LOAD.
- `jam_rst` out 1: active-high reset to the JAM.
- `W` in 3, `J` in 3: lookup address from the JAM.
- `Cost` out 7: `table[W*8+J]`, purely combinational.
- `Valid` in 1, `MinCost` in 9, `MatchCount` in 4: JAM result.
- `done` out 1, `timeout` out 1, `res_min_cost` out 9, `res_match_count` out 4, `run_cycles` out 24: captured result.

## Operation
- **States.** LOAD, READY, HOLD, RUN, DONE.
- **Reset values.**
  - State LOAD, write pointer 0, all 64 table entries 0.
  - `load_ready`=1, `jam_rst`=1.
  - `done`, `timeout`, `res_*`, `run_cycles` all 0.
- **LOAD.**
  - `load_ready`=1.
  - Each cycle with `load_valid`&`load_ready` writes `table[ptr]` and increments `ptr`.
  - On the 64th accept, go to READY; `load_ready` is 0 from the next cycle.
- **READY.** On `start`, go to HOLD and clear `done`, `timeout` and `run_cycles`.
- **HOLD.**
  - `jam_rst`=1 for exactly `RST_HOLD` cycles, then go to RUN.
  - The cycle counter is cleared in HOLD.
- **RUN.**
  - `jam_rst`=0.
  - The counter is 1 in the first RUN cycle and increments every cycle.
  - When `Valid`=1 is sampled: latch `MinCost`, `MatchCount` and the counter into `res_*`/`run_cycles`, then go to DONE.
  - When the counter equals `TIMEOUT_CYCLES` without `Valid`: go to DONE with `timeout`=1, `res_*`=0, `run_cycles`=`TIMEOUT_CYCLES`.
- **DONE.**
  - `done`=1 and `jam_rst`=1; outputs stay held.
  - `start` goes to HOLD, reusing the same table.
  - `reload` goes to LOAD with `ptr`=0; the table is not cleared, and entries are overwritten as they are loaded.
- `jam_rst` is 1 in every state except RUN.
- **Ignored inputs.**
  - `Valid` outside RUN.
  - `start` in LOAD, HOLD and RUN.
  - `reload` outside READY and DONE; in READY, `reload` goes to LOAD.
  - `load_valid` outside LOAD.
- **Simultaneous events.**
  - `start` and `reload` in the same cycle: `reload` wins.
  - `Valid` in the same cycle the counter reaches `TIMEOUT_CYCLES`: `Valid` wins, `timeout`=0.
- **Asynchronous reset at any time, including mid-RUN or mid-LOAD:** immediately restores all reset values. The table clears, so `Cost` becomes 0 and `jam_rst` becomes 1.

## Timing
- `Cost` is combinational from `W`/`J` and the table: zero latency.
- A table write accepted in cycle N is visible on `Cost` from cycle N+1.
- `done` rises in the cycle after `Valid` is sampled (registered) and stays high until `start`, `reload` or reset.
- `jam_rst` falls the cycle after the last HOLD cycle and rises the cycle after `Valid` or timeout.
- **Load time.** A full load takes 64 accept cycles minimum. Gaps in `load_valid` only stall; they never drop or duplicate entries.

## Structure
- **Package `jam_pkg`** holds:
  - the state enum;
  - `COST_W`=7, `MIN_COST_W`=9, `MATCH_W`=4, `IDX_W`=3, `TABLE_DEPTH`=64, `CNT_W`=24.
- **Sub-module `jam_cost_table`:**
  - 64×7 register file with asynchronous clear;
  - one synchronous write port (6-bit address);
  - one combinational read port addressed by `{W,J}`.
- The FSM, pointer and counters live in `jam_cost_server`.

## Test plan
1. **Load and lookup.** Load entries with value W*8+J, one per cycle.
   - `load_ready` falls after the 64th beat.
   - `W`=5, `J`=3 gives `Cost`=43 in the same cycle.
   - `W`=7, `J`=7 gives 63.
2. **Stalled load.** Toggle `load_valid` every other cycle while loading the same pattern.
   - All 64 lookups match, and the block reaches READY after exactly 64 accepts.
3. **Nominal run.** `start`; the model JAM asserts `Valid` in RUN cycle 100 with `MinCost`=245, `MatchCount`=2.
   - `jam_rst` is high for exactly 3 HOLD cycles, then low.
   - Next cycle: `done`=1, `res_min_cost`=245, `res_match_count`=2, `run_cycles`=100, `timeout`=0, `jam_rst`=1.
4. **Timeout.** With `TIMEOUT_CYCLES`=50 and `Valid` never asserted:
   - `done`=1, `timeout`=1, `res_*`=0, `run_cycles`=50.
   - Repeat with `Valid` asserted in cycle 50: `timeout`=0, `run_cycles`=50.
5. **Control collision.** In DONE, pulse `start` and `reload` together.
   - The block enters LOAD with `load_ready`=1 and `done` still held until `start`.
   - The table keeps its old values until overwritten.
6. **Reset mid-run.** Assert `RST_n` low during RUN cycle 20.
   - Same cycle, asynchronously: `jam_rst`=1, `done`=0, `Cost`=0 for all addresses.
   - After release: state LOAD, `load_ready`=1.
